// File: rtl/ysyx_24080006_mdu_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface ysyx_24080006_mdu_if;
  logic        valid_i;
  logic        ready_o;
  logic        signed_a_i;
  logic        signed_b_i;
  logic [1:0]  mdu_op_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic        flush_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;

  // The MDU itself is the slave; the execute stage drives requests as master.
  modport slave (
    input  valid_i, signed_a_i, signed_b_i, mdu_op_i, op_a_i, op_b_i, flush_i, ready_i,
    output ready_o, valid_o, result_o
  );

  modport master (
    output valid_i, signed_a_i, signed_b_i, mdu_op_i, op_a_i, op_b_i, flush_i, ready_i,
    input  ready_o, valid_o, result_o
  );
endinterface

// File: rtl/ysyx_24080006_mdu.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, followed by a one-cycle sign fix.
module ysyx_24080006_mdu #(
  parameter int unsigned ITER = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  ysyx_24080006_mdu_if.slave   mdu
);

  localparam int unsigned CNT_W = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;
  typedef enum logic [1:0] {MULL, MULH, DIV, REM} mdu_op_e;

  state_e             r_state;
  state_e             w_state_nxt;
  mdu_op_e            r_op;
  logic               r_sign_a;
  logic               r_sign_b;
  logic [31:0]        r_mag_a;   // multiplier (shifts right) or dividend (shifts left)
  logic [31:0]        r_mag_b;   // multiplicand or divisor
  logic [63:0]        r_acc;     // product, or {remainder, quotient}
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_result;

  mdu_op_e            w_op;
  logic               w_is_div;
  logic               w_sign_a;
  logic               w_sign_b;
  logic [31:0]        w_mag_a;
  logic [31:0]        w_mag_b;
  logic               w_div_zero;
  logic               w_accept;
  logic               w_last;
  logic [32:0]        w_mul_sum;
  logic [32:0]        w_rem_sh;
  logic [32:0]        w_diff;
  logic [63:0]        w_acc_nxt;
  logic [31:0]        w_mag_a_nxt;
  logic [63:0]        w_prod_fix;
  logic [31:0]        w_fix_res;

  // Request decode: signs and magnitudes; 0x80000000 negates to itself.
  always_comb begin
    w_op       = mdu_op_e'(mdu.mdu_op_i);
    w_is_div   = mdu.mdu_op_i[1];
    w_sign_a   = mdu.signed_a_i & mdu.op_a_i[31];
    w_sign_b   = (w_is_div ? mdu.signed_a_i : mdu.signed_b_i) & mdu.op_b_i[31];
    w_mag_a    = w_sign_a ? (~mdu.op_a_i + 32'd1) : mdu.op_a_i;
    w_mag_b    = w_sign_b ? (~mdu.op_b_i + 32'd1) : mdu.op_b_i;
    w_div_zero = w_is_div && (mdu.op_b_i == '0);
    w_accept   = (r_state == IDLE) && mdu.valid_i && !mdu.flush_i;
    w_last     = (r_cnt == CNT_W'(ITER - 1));
  end

  // One iteration step; the dividend bits are fed into the remainder from
  // r_mag_a's MSB so the accumulator can start cleared for both operations.
  always_comb begin
    w_mul_sum   = {1'b0, r_acc[63:32]} + (r_mag_a[0] ? {1'b0, r_mag_b} : 33'd0);
    w_rem_sh    = {r_acc[63:32], r_mag_a[31]};
    w_diff      = w_rem_sh - {1'b0, r_mag_b};
    w_acc_nxt   = r_acc;
    w_mag_a_nxt = r_mag_a;
    if (r_op == DIV || r_op == REM) begin
      w_mag_a_nxt = {r_mag_a[30:0], 1'b0};
      if (!w_diff[32]) w_acc_nxt = {w_diff[31:0], r_acc[30:0], 1'b1};
      else             w_acc_nxt = {w_rem_sh[31:0], r_acc[30:0], 1'b0};
    end else begin
      w_mag_a_nxt = {1'b0, r_mag_a[31:1]};
      w_acc_nxt   = {w_mul_sum, r_acc[31:1]};
    end
  end

  // Sign correction applied in FIX.
  always_comb begin
    w_prod_fix = (r_sign_a ^ r_sign_b) ? (~r_acc + 64'd1) : r_acc;
    w_fix_res  = '0;
    case (r_op)
      MULL: w_fix_res = w_prod_fix[31:0];
      MULH: w_fix_res = w_prod_fix[63:32];
      DIV:  w_fix_res = (r_sign_a ^ r_sign_b) ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
      REM:  w_fix_res = r_sign_a ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];
      default: w_fix_res = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic; flush overrides everything, including a DONE handshake.
  always_comb begin
    w_state_nxt = r_state;
    if (mdu.flush_i) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: if (mdu.valid_i) w_state_nxt = w_div_zero ? DONE : CALC;
        CALC: if (w_last) w_state_nxt = FIX;
        FIX:  w_state_nxt = DONE;
        DONE: if (mdu.ready_i) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Outputs decoded from state only.
  always_comb begin
    mdu.ready_o  = (r_state == IDLE);
    mdu.valid_o  = (r_state == DONE);
    mdu.result_o = r_result;
  end

  // Datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_op     <= MULL;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_mag_a  <= '0;
      r_mag_b  <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (!mdu.flush_i) begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_op     <= w_op;
          r_sign_a <= w_sign_a;
          r_sign_b <= w_sign_b;
          r_mag_a  <= w_mag_a;
          r_mag_b  <= w_mag_b;
          r_acc    <= '0;
          r_cnt    <= '0;
          if (w_div_zero) r_result <= (w_op == DIV) ? '1 : mdu.op_a_i;
        end
        CALC: begin
          r_acc   <= w_acc_nxt;
          r_mag_a <= w_mag_a_nxt;
          if (!w_last) r_cnt <= r_cnt + 1'b1;
        end
        FIX: r_result <= w_fix_res;
        default: ;
      endcase
    end
  end

endmodule
